foo_arb: RTL
============

# foo_arb

Round-robin arbiter that shares one downstream foo burst channel among `N_REQ` requesters. Each requester presents valid/ready/last bursts. The arbiter locks the channel to one winner per burst and passes beats through combinationally. A beat cap bounds any single hold. It sits between the requester submodules and the single shared `foo_intf` consumer port.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_W`, default 32: beat payload width.
- `MAX_BEATS`, default 16: maximum beats per grant, ≥1.

Ports:
- `clk` in, 1: sole clock, rising edge.
- `rst` in, 1: reset, synchronous, active-high.
- `req_valid` in, N_REQ: per-requester beat valid.
- `req_data` in, N_REQ*DATA_W: requester i occupies slice [i*DATA_W +: DATA_W].
- `req_last` in, N_REQ: final beat of the requester's burst.
- `req_ready` out, N_REQ: beat accepted from requester i.
- `out_valid` out, 1: beat valid on the shared channel.
- `out_data` out, DATA_W: shared channel payload.
- `out_last` out, 1: final beat of the granted burst.
- `out_ready` in, 1: downstream accepts the beat.
- `grant_idx` out, $clog2(N_REQ): current or last winner.
- `busy` out, 1: channel locked to `grant_idx`.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - If any `req_valid` is high, pick the first asserted index scanning from `last_win+1` upward, modulo N_REQ.
  - Register the pick into `grant_idx` and set `last_win` to it.
  - Clear `beat_cnt` and go to BUSY.
  - If no `req_valid` is high, stay in IDLE.
- BUSY:
  - `out_valid = req_valid[grant_idx]` and `out_data = req_data[grant_idx]`.
  - `out_last = req_last[grant_idx] | (beat_cnt == MAX_BEATS-1)`.
  - `req_ready[grant_idx] = out_ready`; all other `req_ready` bits are 0.
- Handshake: a beat transfers when `out_valid && out_ready`. On each transfer, `beat_cnt` increments.
- Burst end: a transfer with `out_last=1` returns the FSM to IDLE. A cap-forced end releases the grant even though the requester did not assert last. That requester re-arbitrates for the remainder of its burst.
- `busy` = (state == BUSY).
- In IDLE: `out_valid`, `out_last` and all `req_ready` are 0. `out_data` is don't-care and is driven as 0.
- `beat_cnt` width is $clog2(MAX_BEATS+1). It never wraps, because the cap forces release first.
- If the winner drops `req_valid` mid-burst, the grant is held, `out_valid` goes 0, and no timeout applies.
- Simultaneous requests in IDLE: round-robin order decides the winner. A requester that becomes valid in the same cycle as another's release competes on the next IDLE cycle.

## Timing
- Reset values: state=IDLE, `last_win`=N_REQ-1 (so index 0 has first priority), `grant_idx`=0, `busy`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `req_ready`=0, `beat_cnt`=0.
- Arbitration latency: the request is seen in IDLE on cycle T; the first beat can transfer in cycle T+1.
- Beat path: combinational from `req_*` and `out_ready` to `out_*` and `req_ready`; zero added latency.
- Back-to-back bursts: one mandatory IDLE bubble cycle after every last-beat transfer.
- `rst` asserted during BUSY: on the next edge, everything returns to reset values and the in-flight burst is abandoned. Upstream must restart it.
- Fairness: with all N_REQ requesters continuously valid, each is granted exactly once per N_REQ grants.

## Structure
- Package `foo_arb_pkg` holds:
  - the state enum `foo_arb_state_e` {IDLE, BUSY};
  - localparam helpers for index width;
  - shared constants such as the default `MAX_BEATS`.
- Sub-module `foo_rr_pick`: a purely combinational rotate-priority picker.
  - Inputs: `req` vector and `last_win`.
  - Outputs: `any` and `pick` index.
  - Instantiated once in `foo_arb` and unit-testable alone.
- `foo_arb` owns the FSM, `last_win`, `beat_cnt` and the output muxing.

## Test plan
- Reset then single requester: `req_valid`=4'b0100 with a 3-beat burst, `out_ready`=1 -> `grant_idx`=2, `busy` rises 1 cycle later, 3 transfers with `out_last` on the 3rd, then IDLE.
- All four requesters continuously valid with 1-beat bursts -> grant order 0,1,2,3,0,…, with one IDLE cycle between grants.
- Backpressure: `out_ready` toggles 1,0,1,0 during a 4-beat burst from requester 1 -> `req_ready[1]` mirrors `out_ready`, transfers happen only on ready cycles, and other `req_ready` bits stay 0.
- Beat cap: `MAX_BEATS`=4, requester 3 sends 6 beats with last on beat 6 -> forced `out_last` on beat 4, release, then requester 3 re-wins and sends beats 5–6.
- Mid-burst valid drop then `rst`: the winner deasserts valid for 3 cycles -> `busy` held and `out_valid`=0. Asserting `rst` in BUSY -> next cycle all outputs equal reset values, and requester 0 has top priority.

Source files
------------

// File: rtl/foo_arb_pkg.sv
// Shared types and constants for the foo round-robin burst arbiter.
// Imported by the picker and by the arbiter top.
package foo_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } foo_arb_state_e;

    localparam int DEFAULT_N_REQ     = 4;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_MAX_BEATS = 16;

    // A single requester would still need one index bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough to hold MAX_BEATS itself, so the counter never wraps.
    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/foo_rr_pick.sv
// Combinational rotate-priority picker: returns the first asserted request
// found scanning upward from last_win+1, modulo N_REQ.
module foo_rr_pick
    import foo_arb_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_win,
    output logic             any,
    output logic [IDX_W-1:0] pick
);

    int idx;

    // Scan from the farthest offset down to the nearest, so the nearest
    // asserted request after last_win overwrites any earlier match.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        idx  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_win) + k) % N_REQ;
            if (req[idx]) begin
                any  = 1'b1;
                pick = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/foo_arb.sv
// Round-robin arbiter sharing one foo burst channel among N_REQ requesters.
// Grants are locked per burst; beats pass through combinationally.
module foo_arb
    import foo_arb_pkg::*;
#(
    parameter int N_REQ     = DEFAULT_N_REQ,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BEATS = DEFAULT_MAX_BEATS,
    localparam int IDX_W    = idx_width(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(MAX_BEATS);

    foo_arb_state_e   state;
    logic [IDX_W-1:0] last_win;
    logic [CNT_W-1:0] beat_cnt;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             cap_hit;
    logic             xfer;

    foo_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req      (req_valid),
        .last_win (last_win),
        .any      (pick_any),
        .pick     (pick_idx)
    );

    assign cap_hit = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign xfer    = out_valid && out_ready;
    assign busy    = (state == BUSY);

    // last_win resets to the top index so requester 0 wins the first scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_win  <= IDX_W'(N_REQ - 1);
            grant_idx <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_idx <= pick_idx;
                        last_win  <= pick_idx;
                        beat_cnt  <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A cap-forced last releases the grant mid-burst; the requester then
    // competes again for the rest of its burst.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state == BUSY) begin
            out_valid            = req_valid[grant_idx];
            out_data             = req_data[int'(grant_idx)*DATA_W +: DATA_W];
            out_last             = req_last[grant_idx] | cap_hit;
            req_ready[grant_idx] = out_ready;
        end
    end

endmodule
